dmem_arbiter: RTL and testbench

Two-port arbiter in front of the single-port word-addressed data memory (`dmem`: combinational read, synchronous write). It shares the memory between the pipeline's MEM stage (core port) and a DMA/debug loader (dma port). The core port has fixed priority, and a starvation counter guarantees the DMA port forward progress. Each accepted access gets a registered, one-cycle-latency response (read data plus error flag).

---
 rtl/mem_pkg.sv | 15 +
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory path.
//   port_e     - identifies which requester owns the memory in a cycle
//   ADDR_W     - byte-address width used by dmem clients
//   is_aligned - word-alignment check, shared with the LSU
package mem_pkg;

  typedef enum logic {PORT_CORE, PORT_DMA} port_e;

  localparam int ADDR_W = 32;

  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return (addr & ADDR_W'(3)) == '0;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage (core port, fixed priority) and a DMA/debug loader (dma port). A
// starvation counter forces a DMA win after STARVE_LIMIT lost contended cycles.
// Every accepted access returns a registered one-cycle response.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata         core request
//   c_gnt                             core accepted this cycle (combinational)
//   c_rvalid/c_rdata/c_err            core response (registered)
//   d_*                               DMA port, same meanings as core
//   mem_w_en/mem_addr/mem_w_d         drive to dmem
//   mem_r_d                           dmem combinational read data
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [WIDTH-1:0]  c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [WIDTH-1:0]  c_rdata,
  output logic              c_err,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WIDTH-1:0]  d_rdata,
  output logic              d_err,

  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_w_d,
  input  logic [WIDTH-1:0]  mem_r_d
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  port_e            win;
  logic             c_ok;
  logic             d_ok;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic             c_rvalid_q, d_rvalid_q;
  logic             c_err_q, d_err_q;
  logic [WIDTH-1:0] c_rdata_q, d_rdata_q;

  assign c_ok = is_aligned(c_addr);
  assign d_ok = is_aligned(d_addr);

  always_comb begin
    win          = PORT_CORE;
    c_gnt        = 1'b0;
    d_gnt        = 1'b0;
    starve_cnt_d = starve_cnt_q;

    // Grants are held off during reset so nothing is accepted into a
    // response register that is being cleared.
    if (rst_n) begin
      if (c_req && d_req) begin
        win = (starve_cnt_q == CNT_MAX) ? PORT_DMA : PORT_CORE;
      end else if (d_req) begin
        win = PORT_DMA;
      end
      c_gnt = c_req && (win == PORT_CORE);
      d_gnt = d_req && (win == PORT_DMA);
    end

    if (d_gnt || !d_req) begin
      starve_cnt_d = '0;
    end else if (c_gnt && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    // Idle cycles park the memory address on the core port.
    mem_addr = (win == PORT_DMA) ? d_addr  : c_addr;
    mem_w_d  = (win == PORT_DMA) ? d_wdata : c_wdata;

    // Misaligned writes are suppressed and reported through x_err instead.
    mem_w_en = (c_gnt && c_we && c_ok) || (d_gnt && d_we && d_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      c_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      c_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      c_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      c_rvalid_q   <= c_gnt;
      d_rvalid_q   <= d_gnt;
      c_err_q      <= c_gnt && !c_ok;
      d_err_q      <= d_gnt && !d_ok;
      // rdata only moves on aligned reads; writes and faults keep the old word.
      if (c_gnt && !c_we && c_ok) c_rdata_q <= mem_r_d;
      if (d_gnt && !d_we && d_ok) d_rdata_q <= mem_r_d;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_err    = c_err_q;
  assign d_err    = d_err_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem attached
// (combinational read, synchronous write, 256 words).
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_w_en;
  logic [31:0] mem_addr, mem_w_d, mem_r_d;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_w_d(mem_w_d),
    .mem_r_d(mem_r_d)
  );

  logic [31:0] mem_arr [0:255];
  assign mem_r_d = mem_arr[mem_addr[9:2]];
  always @(posedge clk) if (mem_w_en) mem_arr[mem_addr[9:2]] <= mem_w_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    c_req = req; c_we = we; c_addr = addr; c_wdata = wdata;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    d_req = req; d_we = we; d_addr = addr; d_wdata = wdata;
  endtask

  logic [2:0] exp_cnt;
  logic       exp_d, prev_d;

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    rst_n = 1'b0;
    drive_c(1'b1, 1'b0, 32'h0, 32'h0);
    drive_d(1'b1, 1'b0, 32'h4, 32'h0);

    // reset state, requests present but grants must stay low
    #3;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_c_err", c_err, 0);
    chk("rst_d_err", d_err, 0);
    chk("rst_w_en", mem_w_en, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // core write then read of 0x10
    drive_c(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    chk("cw_gnt", c_gnt, 1);
    chk("cw_w_en", mem_w_en, 1);
    tick();
    chk("cw_rvalid", c_rvalid, 1);
    chk("cw_err", c_err, 0);
    drive_c(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk("cr_gnt", c_gnt, 1);
    chk("cr_w_en", mem_w_en, 0);
    tick();
    drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    chk("cr_rvalid", c_rvalid, 1);
    chk("cr_rdata", c_rdata, 32'hDEADBEEF);
    chk("cr_err", c_err, 0);
    tick();
    chk("cr_rvalid_pulse", c_rvalid, 0);

    // contention with both reads held: C C C C D C C C C D
    drive_c(1'b1, 1'b0, 32'h0, 32'h0);
    drive_d(1'b1, 1'b0, 32'h4, 32'h0);
    exp_cnt = 3'd0;
    prev_d  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_d = (exp_cnt == 3'd4);
      chk($sformatf("cont_c_gnt_%0d", i), c_gnt, !exp_d);
      chk($sformatf("cont_d_gnt_%0d", i), d_gnt, exp_d);
      chk($sformatf("cont_cnt_%0d", i), dut.starve_cnt_q, exp_cnt);
      chk($sformatf("cont_addr_%0d", i), mem_addr, exp_d ? 32'h4 : 32'h0);
      chk($sformatf("cont_d_rvalid_%0d", i), d_rvalid, prev_d);
      tick();
      prev_d  = exp_d;
      exp_cnt = exp_d ? 3'd0 : exp_cnt + 3'd1;
    end
    chk("cont_cnt_after", dut.starve_cnt_q, 0);
    drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // cross-port read-after-write on 0x40
    drive_d(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5);
    #1;
    chk("raw_d_gnt", d_gnt, 1);
    chk("raw_w_en", mem_w_en, 1);
    tick();
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    drive_c(1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("raw_c_gnt", c_gnt, 1);
    chk("raw_d_rvalid", d_rvalid, 1);
    chk("raw_d_err", d_err, 0);
    tick();
    drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    chk("raw_c_rvalid", c_rvalid, 1);
    chk("raw_c_rdata", c_rdata, 32'hA5A5A5A5);

    // DMA loads a known word, then a misaligned write must not touch it
    drive_d(1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    chk("dr_rdata", d_rdata, 32'hDEADBEEF);
    drive_d(1'b1, 1'b1, 32'h22, 32'h12345678);
    #1;
    chk("mis_d_gnt", d_gnt, 1);
    chk("mis_w_en", mem_w_en, 0);
    tick();
    chk("mis_rvalid", d_rvalid, 1);
    chk("mis_err", d_err, 1);
    chk("mis_rdata_hold", d_rdata, 32'hDEADBEEF);
    drive_d(1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    chk("mis_read_rvalid", d_rvalid, 1);
    chk("mis_read_err", d_err, 0);
    chk("mis_read_rdata", d_rdata, 32'h0);

    // reset in the middle of operation
    drive_c(1'b1, 1'b0, 32'h10, 32'h0);
    drive_d(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    chk("mid_c_gnt", c_gnt, 1);
    tick();
    chk("mid_c_rvalid", c_rvalid, 1);
    chk("mid_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("mid_cnt", dut.starve_cnt_q, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", c_rvalid, 0);
    chk("mid_rst_rdata", c_rdata, 0);
    chk("mid_rst_cnt", dut.starve_cnt_q, 0);
    chk("mid_rst_c_gnt", c_gnt, 0);
    chk("mid_rst_d_gnt", d_gnt, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_rvalid", c_rvalid, 0);
    #2 rst_n = 1'b1;
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    drive_c(1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("mid_resume_gnt", c_gnt, 1);
    tick();
    chk("mid_resume_rvalid", c_rvalid, 1);
    chk("mid_resume_rdata", c_rdata, 32'hA5A5A5A5);

    // idle
    drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    drive_d(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle_w_en_%0d", i), mem_w_en, 0);
      chk($sformatf("idle_c_rvalid_%0d", i), c_rvalid, 0);
      chk($sformatf("idle_d_rvalid_%0d", i), d_rvalid, 0);
    end
    chk("idle_c_rdata", c_rdata, 32'hA5A5A5A5);
    chk("idle_d_rdata", d_rdata, 32'h0);
    chk("idle_cnt", dut.starve_cnt_q, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
